// File: rtl/ppu_vram_pkg.sv
// Shared types and defaults for the PPU VRAM arbiter: read-owner tags and
// memory geometry.
package ppu_vram_pkg;

    typedef enum logic [1:0] {
        OWN_NONE   = 2'd0,
        OWN_RENDER = 2'd1,
        OWN_CPU    = 2'd2
    } owner_e;

    localparam int VRAM_ADDR_W      = 14;
    localparam int VRAM_DATA_W      = 8;
    localparam int STARVE_LIMIT_DEF = 32;

endpackage

// File: rtl/ppu_vram_tag_pipe.sv
// Owner-tag delay line: a tag entering with a VRAM read emerges when that
// read's data is present on the memory bus.
module ppu_vram_tag_pipe
    import ppu_vram_pkg::*;
#(
    parameter int DEPTH = 1
) (
    input  logic   clk,
    input  logic   rst,
    input  owner_e i_tag,
    output owner_e o_tag
);

    owner_e stage_q [DEPTH];
    owner_e stage_d [DEPTH];

    always_comb begin
        stage_d[0] = i_tag;
        for (int i = 1; i < DEPTH; i++) begin
            stage_d[i] = stage_q[i-1];
        end
    end

    // Clearing to NONE drops any reads in flight at reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= OWN_NONE;
            end
        end else begin
            stage_q <= stage_d;
        end
    end

    assign o_tag = stage_q[DEPTH-1];

endmodule

// File: rtl/ppu_vram_arbiter.sv
// Single-port VRAM arbiter between the PPU render fetcher and the CPU PPUDATA
// port, with window-dependent priority, a CPU starvation guard and tagged reads.
module ppu_vram_arbiter
    import ppu_vram_pkg::*;
#(
    parameter int ADDR_WIDTH   = VRAM_ADDR_W,
    parameter int DATA_WIDTH   = VRAM_DATA_W,
    parameter int READ_LATENCY = 1,
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_vblank,
    input  logic                  i_render_en,
    input  logic                  i_rnd_req,
    input  logic [ADDR_WIDTH-1:0] i_rnd_addr,
    output logic                  o_rnd_ack,
    output logic [DATA_WIDTH-1:0] o_rnd_rdata,
    output logic                  o_rnd_rvalid,
    input  logic                  i_cpu_req,
    input  logic                  i_cpu_we,
    input  logic [ADDR_WIDTH-1:0] i_cpu_addr,
    input  logic [DATA_WIDTH-1:0] i_cpu_wdata,
    output logic                  o_cpu_ack,
    output logic                  o_cpu_forced,
    output logic [DATA_WIDTH-1:0] o_cpu_rdata,
    output logic                  o_cpu_rvalid,
    output logic [15:0]           o_starve_events,
    output logic                  o_vram_en,
    output logic                  o_vram_we,
    output logic [ADDR_WIDTH-1:0] o_vram_addr,
    output logic [DATA_WIDTH-1:0] o_vram_wdata,
    input  logic [DATA_WIDTH-1:0] i_vram_rdata
);

    localparam int            SW         = $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

    logic window, rnd_elig, cpu_elig, starved, cpu_win, rnd_win;

    logic                  rnd_ack_q, rnd_ack_d;
    logic                  cpu_ack_q, cpu_ack_d;
    logic                  cpu_forced_q, cpu_forced_d;
    logic                  vram_en_q, vram_en_d;
    logic                  vram_we_q, vram_we_d;
    logic [ADDR_WIDTH-1:0] vram_addr_q, vram_addr_d;
    logic [DATA_WIDTH-1:0] vram_wdata_q, vram_wdata_d;
    logic [SW-1:0]         starve_q, starve_d;
    logic [15:0]           starve_events_q, starve_events_d;
    logic [DATA_WIDTH-1:0] rnd_rdata_q, rnd_rdata_d;
    logic                  rnd_rvalid_q, rnd_rvalid_d;
    logic [DATA_WIDTH-1:0] cpu_rdata_q, cpu_rdata_d;
    logic                  cpu_rvalid_q, cpu_rvalid_d;

    owner_e issue_tag, ret_tag;

    // Arbitration decision; a requester whose ack is showing is still holding
    // the request just granted, so it is not eligible this cycle.
    always_comb begin
        window   = i_render_en && !i_vblank;
        rnd_elig = i_rnd_req && !rnd_ack_q;
        cpu_elig = i_cpu_req && !cpu_ack_q;
        starved  = window && cpu_elig && (starve_q == STARVE_MAX);
        cpu_win  = 1'b0;
        rnd_win  = 1'b0;
        if (window) begin
            if (cpu_elig && (starved || !rnd_elig)) begin
                cpu_win = 1'b1;
            end else if (rnd_elig) begin
                rnd_win = 1'b1;
            end
        end else begin
            if (cpu_elig) begin
                cpu_win = 1'b1;
            end else if (rnd_elig) begin
                rnd_win = 1'b1;
            end
        end
    end

    always_comb begin
        rnd_ack_d    = rnd_win;
        cpu_ack_d    = cpu_win;
        cpu_forced_d = cpu_win && starved;
        vram_en_d    = rnd_win || cpu_win;
        vram_we_d    = cpu_win && i_cpu_we;
        vram_addr_d  = vram_addr_q;
        vram_wdata_d = vram_wdata_q;
        if (cpu_win) begin
            vram_addr_d = i_cpu_addr;
            if (i_cpu_we) begin
                vram_wdata_d = i_cpu_wdata;
            end
        end else if (rnd_win) begin
            vram_addr_d = i_rnd_addr;
        end
    end

    // Starve counter only runs while the CPU is actually being held off.
    always_comb begin
        starve_d        = starve_q;
        starve_events_d = starve_events_q;
        if (!i_cpu_req || !window || cpu_win) begin
            starve_d = '0;
        end else if (cpu_elig && (starve_q != STARVE_MAX)) begin
            starve_d = starve_q + 1'b1;
        end
        if (cpu_forced_d && (starve_events_q != 16'hFFFF)) begin
            starve_events_d = starve_events_q + 16'd1;
        end
    end

    // Tag enters alongside the registered strobe so it reaches the end of the
    // pipe in the cycle the memory presents that read's data.
    always_comb begin
        issue_tag = OWN_NONE;
        if (vram_en_q && !vram_we_q) begin
            issue_tag = cpu_ack_q ? OWN_CPU : OWN_RENDER;
        end
    end

    ppu_vram_tag_pipe #(
        .DEPTH (READ_LATENCY)
    ) u_tag_pipe (
        .clk   (clk),
        .rst   (rst),
        .i_tag (issue_tag),
        .o_tag (ret_tag)
    );

    always_comb begin
        rnd_rvalid_d = (ret_tag == OWN_RENDER);
        cpu_rvalid_d = (ret_tag == OWN_CPU);
        rnd_rdata_d  = rnd_rvalid_d ? i_vram_rdata : rnd_rdata_q;
        cpu_rdata_d  = cpu_rvalid_d ? i_vram_rdata : cpu_rdata_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rnd_ack_q       <= 1'b0;
            cpu_ack_q       <= 1'b0;
            cpu_forced_q    <= 1'b0;
            vram_en_q       <= 1'b0;
            vram_we_q       <= 1'b0;
            vram_addr_q     <= '0;
            vram_wdata_q    <= '0;
            starve_q        <= '0;
            starve_events_q <= '0;
            rnd_rdata_q     <= '0;
            rnd_rvalid_q    <= 1'b0;
            cpu_rdata_q     <= '0;
            cpu_rvalid_q    <= 1'b0;
        end else begin
            rnd_ack_q       <= rnd_ack_d;
            cpu_ack_q       <= cpu_ack_d;
            cpu_forced_q    <= cpu_forced_d;
            vram_en_q       <= vram_en_d;
            vram_we_q       <= vram_we_d;
            vram_addr_q     <= vram_addr_d;
            vram_wdata_q    <= vram_wdata_d;
            starve_q        <= starve_d;
            starve_events_q <= starve_events_d;
            rnd_rdata_q     <= rnd_rdata_d;
            rnd_rvalid_q    <= rnd_rvalid_d;
            cpu_rdata_q     <= cpu_rdata_d;
            cpu_rvalid_q    <= cpu_rvalid_d;
        end
    end

    assign o_rnd_ack       = rnd_ack_q;
    assign o_rnd_rdata     = rnd_rdata_q;
    assign o_rnd_rvalid    = rnd_rvalid_q;
    assign o_cpu_ack       = cpu_ack_q;
    assign o_cpu_forced    = cpu_forced_q;
    assign o_cpu_rdata     = cpu_rdata_q;
    assign o_cpu_rvalid    = cpu_rvalid_q;
    assign o_starve_events = starve_events_q;
    assign o_vram_en       = vram_en_q;
    assign o_vram_we       = vram_we_q;
    assign o_vram_addr     = vram_addr_q;
    assign o_vram_wdata    = vram_wdata_q;

endmodule

// File: tb/tb_ppu_vram_arbiter.sv
// Bench for ppu_vram_arbiter: table-driven grant vectors plus hand sequences,
// checked through a grant/read-return scoreboard.
module tb_ppu_vram_arbiter;

    localparam int L = 1;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_vblank, i_render_en;
    logic        i_rnd_req, i_cpu_req, i_cpu_we;
    logic [13:0] i_rnd_addr, i_cpu_addr;
    logic [7:0]  i_cpu_wdata;

    logic        o_rnd_ack, o_rnd_rvalid, o_cpu_ack, o_cpu_forced, o_cpu_rvalid;
    logic [7:0]  o_rnd_rdata, o_cpu_rdata, o_vram_wdata, mrd;
    logic [15:0] o_starve_events;
    logic        o_vram_en, o_vram_we;
    logic [13:0] o_vram_addr;

    // second instance with a tiny starvation limit so the guard can fire
    logic        l_rnd_ack, l_rnd_rvalid, l_cpu_ack, l_cpu_forced, l_cpu_rvalid;
    logic [7:0]  l_rnd_rdata, l_cpu_rdata, l_vram_wdata, lrd;
    logic [15:0] l_starve_events;
    logic        l_vram_en, l_vram_we;
    logic [13:0] l_vram_addr;

    ppu_vram_arbiter #(.ADDR_WIDTH(14), .DATA_WIDTH(8), .READ_LATENCY(L), .STARVE_LIMIT(32)) dut (
        .clk(clk), .rst(rst), .i_vblank(i_vblank), .i_render_en(i_render_en),
        .i_rnd_req(i_rnd_req), .i_rnd_addr(i_rnd_addr), .o_rnd_ack(o_rnd_ack),
        .o_rnd_rdata(o_rnd_rdata), .o_rnd_rvalid(o_rnd_rvalid),
        .i_cpu_req(i_cpu_req), .i_cpu_we(i_cpu_we), .i_cpu_addr(i_cpu_addr),
        .i_cpu_wdata(i_cpu_wdata), .o_cpu_ack(o_cpu_ack), .o_cpu_forced(o_cpu_forced),
        .o_cpu_rdata(o_cpu_rdata), .o_cpu_rvalid(o_cpu_rvalid),
        .o_starve_events(o_starve_events), .o_vram_en(o_vram_en), .o_vram_we(o_vram_we),
        .o_vram_addr(o_vram_addr), .o_vram_wdata(o_vram_wdata), .i_vram_rdata(mrd));

    ppu_vram_arbiter #(.ADDR_WIDTH(14), .DATA_WIDTH(8), .READ_LATENCY(L), .STARVE_LIMIT(1)) dut_lim1 (
        .clk(clk), .rst(rst), .i_vblank(i_vblank), .i_render_en(i_render_en),
        .i_rnd_req(i_rnd_req), .i_rnd_addr(i_rnd_addr), .o_rnd_ack(l_rnd_ack),
        .o_rnd_rdata(l_rnd_rdata), .o_rnd_rvalid(l_rnd_rvalid),
        .i_cpu_req(i_cpu_req), .i_cpu_we(i_cpu_we), .i_cpu_addr(i_cpu_addr),
        .i_cpu_wdata(i_cpu_wdata), .o_cpu_ack(l_cpu_ack), .o_cpu_forced(l_cpu_forced),
        .o_cpu_rdata(l_cpu_rdata), .o_cpu_rvalid(l_cpu_rvalid),
        .o_starve_events(l_starve_events), .o_vram_en(l_vram_en), .o_vram_we(l_vram_we),
        .o_vram_addr(l_vram_addr), .o_vram_wdata(l_vram_wdata), .i_vram_rdata(lrd));

    always #5 clk = ~clk;

    // VRAM model: fixed content pattern, one-cycle read latency
    function automatic logic [7:0] pat(input logic [13:0] a);
        return a[7:0] ^ {a[13:8], 2'b01};
    endfunction

    always @(posedge clk) begin
        mrd <= pat(o_vram_addr);
        lrd <= pat(l_vram_addr);
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk = 0;
    int n_bad = 0;

    typedef struct {
        int          cyc;
        bit          cpu;
        bit          we;
        logic [13:0] addr;
        logic [7:0]  wdata;
        bit          forced;
    } grant_t;

    typedef struct {
        int         cyc;
        bit         cpu;
        logic [7:0] data;
    } rd_t;

    grant_t gq[$];
    rd_t    rq[$];
    grant_t mg;
    rd_t    mr;

    typedef struct {
        bit          vb;
        bit          ren;
        bit          rreq;
        logic [13:0] raddr;
        bit          creq;
        bit          cwe;
        logic [13:0] caddr;
        logic [7:0]  cwd;
        bit          cpu_first;
    } vec_t;

    vec_t vt[7];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h want=%0h (cyc %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic exp_grant(input int c, input bit cpu, input bit we, input logic [13:0] a,
                             input logic [7:0] wd, input bit rd_back);
        grant_t g;
        rd_t    r;
        g.cyc = c; g.cpu = cpu; g.we = we; g.addr = a; g.wdata = wd; g.forced = 1'b0;
        gq.push_back(g);
        if (!we && rd_back) begin
            r.cyc = c + 1 + L; r.cpu = cpu; r.data = pat(a);
            rq.push_back(r);
        end
    endtask

    // Requester behaviour: drop req in the cycle its ack is seen.
    task automatic wait_done(input int bound);
        for (int k = 0; k < bound; k++) begin
            if (!i_rnd_req && !i_cpu_req) break;
            step();
            if (o_rnd_ack) i_rnd_req = 1'b0;
            if (o_cpu_ack) i_cpu_req = 1'b0;
        end
        if (i_rnd_req || i_cpu_req) begin
            n_chk++; n_bad++;
            $display("FAIL ack_timeout rnd_req=%0b cpu_req=%0b want both acked", i_rnd_req, i_cpu_req);
            i_rnd_req = 1'b0; i_cpu_req = 1'b0;
        end
    endtask

    task automatic run_vec(input vec_t v);
        int n;
        i_vblank = v.vb; i_render_en = v.ren;
        n = cyc;
        i_rnd_req = v.rreq; i_rnd_addr = v.raddr;
        i_cpu_req = v.creq; i_cpu_we = v.cwe; i_cpu_addr = v.caddr; i_cpu_wdata = v.cwd;
        if (v.rreq && v.creq) begin
            if (v.cpu_first) begin
                exp_grant(n + 1, 1'b1, v.cwe, v.caddr, v.cwd, 1'b1);
                exp_grant(n + 2, 1'b0, 1'b0, v.raddr, 8'h00, 1'b1);
            end else begin
                exp_grant(n + 1, 1'b0, 1'b0, v.raddr, 8'h00, 1'b1);
                exp_grant(n + 2, 1'b1, v.cwe, v.caddr, v.cwd, 1'b1);
            end
        end else if (v.creq) begin
            exp_grant(n + 1, 1'b1, v.cwe, v.caddr, v.cwd, 1'b1);
        end else if (v.rreq) begin
            exp_grant(n + 1, 1'b0, 1'b0, v.raddr, 8'h00, 1'b1);
        end
        wait_done(10);
        repeat (4) step();
    endtask

    // Scoreboard monitor, sampled mid-cycle
    always @(negedge clk) begin
        if (!rst) begin
            if (o_rnd_ack || o_cpu_ack) begin
                n_chk++;
                if (gq.size() == 0) begin
                    n_bad++;
                    $display("FAIL unexpected_ack cyc=%0d rnd=%0b cpu=%0b want none", cyc, o_rnd_ack, o_cpu_ack);
                end else begin
                    mg = gq.pop_front();
                    if (cyc != mg.cyc || o_cpu_ack != mg.cpu || o_rnd_ack == mg.cpu ||
                        o_vram_we != mg.we || o_vram_addr != mg.addr ||
                        (mg.we && o_vram_wdata != mg.wdata) || o_cpu_forced != mg.forced) begin
                        n_bad++;
                        $display("FAIL grant got cyc=%0d cpu=%0b rnd=%0b we=%0b addr=%h wd=%h forced=%0b want cyc=%0d cpu=%0b we=%0b addr=%h wd=%h forced=%0b",
                                 cyc, o_cpu_ack, o_rnd_ack, o_vram_we, o_vram_addr, o_vram_wdata, o_cpu_forced,
                                 mg.cyc, mg.cpu, mg.we, mg.addr, mg.wdata, mg.forced);
                    end
                end
            end
            if (o_rnd_rvalid || o_cpu_rvalid) begin
                n_chk++;
                if (rq.size() == 0) begin
                    n_bad++;
                    $display("FAIL unexpected_rvalid cyc=%0d rnd=%0b cpu=%0b want none", cyc, o_rnd_rvalid, o_cpu_rvalid);
                end else begin
                    mr = rq.pop_front();
                    if (cyc != mr.cyc || o_cpu_rvalid != mr.cpu || o_rnd_rvalid == mr.cpu ||
                        (mr.cpu ? o_cpu_rdata : o_rnd_rdata) != mr.data) begin
                        n_bad++;
                        $display("FAIL rvalid got cyc=%0d cpu=%0b rnd=%0b data=%h want cyc=%0d cpu=%0b data=%h",
                                 cyc, o_cpu_rvalid, o_rnd_rvalid, mr.cpu ? o_cpu_rdata : o_rnd_rdata,
                                 mr.cyc, mr.cpu, mr.data);
                    end
                end
            end
            n_chk++;
            if (o_vram_en != (o_rnd_ack || o_cpu_ack) || (o_vram_we && !o_cpu_ack)) begin
                n_bad++;
                $display("FAIL en_align cyc=%0d en=%0b we=%0b acks=%0b%0b want en==ack, we only with cpu ack",
                         cyc, o_vram_en, o_vram_we, o_rnd_ack, o_cpu_ack);
            end
        end
    end

    initial begin
        int n;
        int acks;
        bit saw;
        logic [15:0] ev1;

        vt[0] = '{vb:1, ren:1, rreq:1, raddr:14'h0010, creq:1, cwe:1, caddr:14'h2005, cwd:8'hA7, cpu_first:1};
        vt[1] = '{vb:0, ren:1, rreq:1, raddr:14'h0010, creq:1, cwe:1, caddr:14'h2005, cwd:8'hA7, cpu_first:0};
        vt[2] = '{vb:0, ren:0, rreq:1, raddr:14'h0456, creq:1, cwe:0, caddr:14'h0123, cwd:8'h00, cpu_first:1};
        vt[3] = '{vb:0, ren:1, rreq:1, raddr:14'h1FFF, creq:1, cwe:0, caddr:14'h3F00, cwd:8'h00, cpu_first:0};
        vt[4] = '{vb:0, ren:1, rreq:0, raddr:14'h0000, creq:1, cwe:1, caddr:14'h3FFF, cwd:8'h5A, cpu_first:1};
        vt[5] = '{vb:1, ren:1, rreq:1, raddr:14'h0000, creq:0, cwe:0, caddr:14'h0000, cwd:8'h00, cpu_first:0};
        vt[6] = '{vb:1, ren:0, rreq:0, raddr:14'h0000, creq:1, cwe:0, caddr:14'h0ABC, cwd:8'h00, cpu_first:1};

        rst = 1'b1;
        i_vblank = 1'b1; i_render_en = 1'b0;
        i_rnd_req = 1'b0; i_rnd_addr = '0;
        i_cpu_req = 1'b0; i_cpu_we = 1'b0; i_cpu_addr = '0; i_cpu_wdata = '0;
        repeat (3) step();
        check("rst_ctrl", {o_rnd_ack, o_cpu_ack, o_cpu_forced, o_rnd_rvalid, o_cpu_rvalid, o_vram_en, o_vram_we}, 0);
        check("rst_bus", {o_vram_addr, o_vram_wdata}, 0);
        check("rst_rdata", {o_rnd_rdata, o_cpu_rdata, o_starve_events}, 0);
        rst = 1'b0;
        step();

        foreach (vt[i]) run_vec(vt[i]);

        // Render held with changing addresses, CPU read pending inside the window
        ev1 = l_starve_events;
        i_vblank = 1'b0; i_render_en = 1'b1;
        n = cyc;
        i_rnd_req = 1'b1; i_rnd_addr = 14'h0100;
        i_cpu_req = 1'b1; i_cpu_we = 1'b0; i_cpu_addr = 14'h23C0;
        exp_grant(n + 1, 1'b0, 1'b0, 14'h0100, 8'h00, 1'b1);
        exp_grant(n + 2, 1'b1, 1'b0, 14'h23C0, 8'h00, 1'b1);
        exp_grant(n + 3, 1'b0, 1'b0, 14'h0101, 8'h00, 1'b1);
        exp_grant(n + 5, 1'b0, 1'b0, 14'h0102, 8'h00, 1'b1);
        for (int k = 0; k < 6; k++) begin
            step();
            if (o_cpu_ack) begin
                i_cpu_req = 1'b0;
                check("lim1_cpu_ack", {l_cpu_ack, l_cpu_forced}, 2'b11);
                check("lim1_events", l_starve_events, ev1 + 16'd1);
            end
            if (o_rnd_ack) i_rnd_addr = i_rnd_addr + 14'd1;
        end
        i_rnd_req = 1'b0;
        if (i_cpu_req) begin
            check("starve_cpu_acked", 0, 1);
            i_cpu_req = 1'b0;
        end
        repeat (4) step();
        check("main_events", o_starve_events, 16'd0);

        // CPU read in flight while the window opens: data stays with the CPU
        i_vblank = 1'b1;
        n = cyc;
        i_cpu_req = 1'b1; i_cpu_we = 1'b0; i_cpu_addr = 14'h0777;
        exp_grant(n + 1, 1'b1, 1'b0, 14'h0777, 8'h00, 1'b1);
        step();
        if (o_cpu_ack) i_cpu_req = 1'b0;
        i_vblank = 1'b0;
        saw = 1'b0;
        for (int k = 0; k < 5; k++) begin
            step();
            if (o_cpu_ack) i_cpu_req = 1'b0;
            if (o_rnd_rvalid) saw = 1'b1;
        end
        check("win_change_no_rnd_rvalid", saw, 0);
        if (i_cpu_req) begin
            check("win_change_cpu_acked", 0, 1);
            i_cpu_req = 1'b0;
        end

        // Render-only stream, req held 6 cycles: acks every other cycle
        i_vblank = 1'b1;
        n = cyc;
        acks = 0;
        i_rnd_req = 1'b1; i_rnd_addr = 14'h0200;
        exp_grant(n + 1, 1'b0, 1'b0, 14'h0200, 8'h00, 1'b1);
        exp_grant(n + 3, 1'b0, 1'b0, 14'h0201, 8'h00, 1'b1);
        exp_grant(n + 5, 1'b0, 1'b0, 14'h0202, 8'h00, 1'b1);
        for (int k = 0; k < 6; k++) begin
            step();
            if (o_rnd_ack) begin
                acks++;
                i_rnd_addr = i_rnd_addr + 14'd1;
            end
        end
        i_rnd_req = 1'b0;
        check("stream_ack_count", acks, 3);
        repeat (4) step();

        // Reset one cycle after a render read ack: the read never returns
        n = cyc;
        i_rnd_req = 1'b1; i_rnd_addr = 14'h0042;
        exp_grant(n + 1, 1'b0, 1'b0, 14'h0042, 8'h00, 1'b0);
        step();
        if (o_rnd_ack) i_rnd_req = 1'b0;
        step();
        i_rnd_req = 1'b0;
        rst = 1'b1;
        step();
        check("mid_rst_ctrl", {o_rnd_ack, o_cpu_ack, o_cpu_forced, o_rnd_rvalid, o_cpu_rvalid, o_vram_en, o_vram_we}, 0);
        check("mid_rst_bus", {o_vram_addr, o_vram_wdata}, 0);
        check("mid_rst_rdata", {o_rnd_rdata, o_cpu_rdata, o_starve_events}, 0);
        check("mid_rst_lim1_events", l_starve_events, 0);
        rst = 1'b0;
        saw = 1'b0;
        for (int k = 0; k < 5; k++) begin
            step();
            if (o_rnd_rvalid || o_cpu_rvalid) saw = 1'b1;
        end
        check("mid_rst_no_rvalid", saw, 0);

        check("grant_queue_drained", gq.size(), 0);
        check("read_queue_drained", rq.size(), 0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout reached at cyc=%0d", cyc);
        $fatal(1, "timeout");
    end

endmodule
